// File: rtl/mask_pkg.sv
// Shared constants, index-width helper and state encoding for the mask builder.
// Latency: none (package only).
// Backpressure: not applicable.
package mask_pkg;

  // Widest mask the builder supports.
  localparam int MB_MAX_BITS = 64;

  // Index width for a given mask width; a one-bit mask still needs a one-bit index.
  function automatic int mb_idx_w(input int bits);
    return (bits <= 1) ? 1 : $clog2(bits);
  endfunction

  // Output register state: EMPTY = output free, FULL = mask held for downstream.
  typedef enum logic {
    MB_EMPTY = 1'b0,
    MB_FULL  = 1'b1
  } mb_state_e;

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational bit index to one-hot decoder with out-of-range flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies the result with its own handshake.
module idx_onehot_dec
  import mask_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CLZ      = 0,
  parameter int LOG_BITS = mb_idx_w(BITS)
) (
  input  logic [LOG_BITS-1:0] idx_i,
  output logic [BITS-1:0]     onehot_o,
  output logic                oor_o
);

  // With CLZ numbering index 0 is the MSB, so a leading-zero encoder downstream
  // recovers the same index that was written here.
  for (genvar g = 0; g < BITS; g++) begin : g_bit
    localparam int POS = (CLZ != 0) ? (BITS - 1 - g) : g;
    assign onehot_o[POS] = (idx_i == LOG_BITS'(g));
  end

  // Only reachable when BITS is not a power of two (or BITS is 1).
  assign oor_o = (32'(idx_i) >= 32'(BITS));

endmodule

// File: rtl/mask_build.sv
// Streaming index-to-bitmask builder; optional duplicate flag under MASK_BUILD_DUP_DETECT_EN.
// Latency: last beat accepted at edge N -> mask_valid_o high after edge N.
// Backpressure: idx_ready_o = !mask_valid_o || mask_ready_i; input stalls while a mask is held.
module mask_build
  import mask_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CLZ      = 0,
  parameter int LOG_BITS = mb_idx_w(BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                idx_valid_i,
  output logic                idx_ready_o,
  input  logic [LOG_BITS-1:0] idx_data_i,
  input  logic                idx_last_i,
  output logic                mask_valid_o,
  input  logic                mask_ready_i,
  output logic [BITS-1:0]     mask_data_o,
  output logic [LOG_BITS:0]   mask_cnt_o,
  output logic                err_range_o,
`ifdef MASK_BUILD_DUP_DETECT_EN
  output logic                err_dup_o,
`endif
  input  logic                err_clr_i
);

  localparam int CW = LOG_BITS + 1;

  if (BITS < 1 || BITS > MB_MAX_BITS) begin : g_bad_bits
    $error("mask_build: BITS must be in 1..64");
  end

  mb_state_e       state_q;
  mb_state_e       state_d;
  logic [BITS-1:0] acc_q;
  logic [BITS-1:0] acc_nxt;
  logic [BITS-1:0] onehot;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nxt;
  logic            idx_oor;
  logic            bit_new;
  logic            accept;
  logic            last_acc;
  logic            load_out;

  idx_onehot_dec #(
    .BITS     (BITS),
    .CLZ      (CLZ),
    .LOG_BITS (LOG_BITS)
  ) u_dec (
    .idx_i    (idx_data_i),
    .onehot_o (onehot),
    .oor_o    (idx_oor)
  );

  assign mask_valid_o = (state_q == MB_FULL);
  assign idx_ready_o  = !mask_valid_o || mask_ready_i;
  assign accept       = idx_valid_i && idx_ready_o;
  assign last_acc     = accept && idx_last_i;

  // An out-of-range index decodes to all zeros, so it leaves mask and count alone.
  assign bit_new = |(onehot & ~acc_q);
  assign acc_nxt = acc_q | onehot;
  assign cnt_nxt = cnt_q + CW'(bit_new);

  // Next state: a last beat always (re)fills the output; a plain handshake empties it.
  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    unique case (state_q)
      MB_EMPTY: begin
        if (last_acc) begin
          state_d  = MB_FULL;
          load_out = 1'b1;
        end
      end
      MB_FULL: begin
        if (last_acc) begin
          state_d  = MB_FULL;
          load_out = 1'b1;
        end else if (mask_ready_i) begin
          state_d = MB_EMPTY;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator and distinct-bit counter; restart on the packet's last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      if (idx_last_i) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_nxt;
      end
    end
  end

  // Output register captures the mask including the last beat's own bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_data_o <= '0;
      mask_cnt_o  <= '0;
    end else if (load_out) begin
      mask_data_o <= acc_nxt;
      mask_cnt_o  <= cnt_nxt;
    end
  end

  // Sticky out-of-range flag; a clear request beats a simultaneous new error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_range_o <= 1'b0;
    end else if (err_clr_i) begin
      err_range_o <= 1'b0;
    end else if (accept && idx_oor) begin
      err_range_o <= 1'b1;
    end
  end

`ifdef MASK_BUILD_DUP_DETECT_EN
  logic dup_hit;
  assign dup_hit = |(onehot & acc_q);

  // Sticky duplicate flag; mask and count are unaffected by a repeat index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_dup_o <= 1'b0;
    end else if (err_clr_i) begin
      err_dup_o <= 1'b0;
    end else if (accept && !idx_oor && dup_hit) begin
      err_dup_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mask_build.sv
// Bench for mask_build: two instances (24-bit LSB-first, 32-bit MSB-first) share one stimulus stream.
// Expected masks come from index lists kept per packet; a negedge monitor pops and compares.
// Random backpressure, error clears and mid-packet resets follow a directed prologue.
module tb_mask_build;

  typedef struct {
    logic [63:0] m;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idx_valid = 1'b0;
  logic [4:0]  idx_data = '0;
  logic        idx_last = 1'b0;
  logic        mask_ready = 1'b0;
  logic        err_clr = 1'b0;

  logic        a_rdy, a_mvld, a_erng;
  logic [23:0] a_mdat;
  logic [5:0]  a_cnt;
  logic        b_rdy, b_mvld, b_erng;
  logic [31:0] b_mdat;
  logic [5:0]  b_cnt;
`ifdef MASK_BUILD_DUP_DETECT_EN
  logic        a_edup, b_edup;
`endif

  int n_vec = 0;
  int n_err = 0;

  exp_t qa[$];
  exp_t qb[$];
  int   pkt[$];
  bit   out_full = 0;
  bit   exp_erng_a = 0;
  bit   exp_dup_a = 0;
  bit   exp_dup_b = 0;
  bit   mon_en = 0;

  always #5 clk = ~clk;

  mask_build #(.BITS(24), .CLZ(0)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_valid_i  (idx_valid),
    .idx_ready_o  (a_rdy),
    .idx_data_i   (idx_data),
    .idx_last_i   (idx_last),
    .mask_valid_o (a_mvld),
    .mask_ready_i (mask_ready),
    .mask_data_o  (a_mdat),
    .mask_cnt_o   (a_cnt),
    .err_range_o  (a_erng),
`ifdef MASK_BUILD_DUP_DETECT_EN
    .err_dup_o    (a_edup),
`endif
    .err_clr_i    (err_clr)
  );

  mask_build #(.BITS(32), .CLZ(1)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_valid_i  (idx_valid),
    .idx_ready_o  (b_rdy),
    .idx_data_i   (idx_data),
    .idx_last_i   (idx_last),
    .mask_valid_o (b_mvld),
    .mask_ready_i (mask_ready),
    .mask_data_o  (b_mdat),
    .mask_cnt_o   (b_cnt),
    .err_range_o  (b_erng),
`ifdef MASK_BUILD_DUP_DETECT_EN
    .err_dup_o    (b_edup),
`endif
    .err_clr_i    (err_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mask from a list of indices: set each in-range index's bit, count the distinct bits.
  function automatic exp_t build(input int ids[$], input int bits, input int clz);
    exp_t r;
    r.m = '0;
    foreach (ids[i]) begin
      if (ids[i] < bits) r.m[(clz != 0) ? (bits - 1 - ids[i]) : ids[i]] = 1'b1;
    end
    r.c = $countones(r.m);
    return r;
  endfunction

  function automatic bit in_pkt(input int ids[$], input int v);
    foreach (ids[i]) if (ids[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle of stimulus; entered just after a rising edge, leaves just after the next.
  task automatic cyc(input bit v, input int idx, input bit last, input bit rdy,
                     input bit clr, input bit rst);
    bit exp_rdy;
    bit acc;
    idx_valid  = v;
    idx_data   = 5'(idx);
    idx_last   = last;
    mask_ready = rdy;
    err_clr    = clr;
    rst_n      = !rst;
    @(negedge clk);
    exp_rdy = !out_full || rdy;
    chk("a_idx_ready", a_rdy, exp_rdy);
    chk("b_idx_ready", b_rdy, exp_rdy);
    chk("a_err_range", a_erng, exp_erng_a);
    chk("b_err_range", b_erng, 0);
`ifdef MASK_BUILD_DUP_DETECT_EN
    chk("a_err_dup", a_edup, exp_dup_a);
    chk("b_err_dup", b_edup, exp_dup_b);
`endif
    @(posedge clk);
    if (rst) begin
      pkt.delete();
      qa.delete();
      qb.delete();
      out_full   = 0;
      exp_erng_a = 0;
      exp_dup_a  = 0;
      exp_dup_b  = 0;
    end else begin
      acc = v && exp_rdy;
      if (clr) begin
        exp_erng_a = 0;
        exp_dup_a  = 0;
        exp_dup_b  = 0;
      end else if (acc) begin
        if (idx >= 24) exp_erng_a = 1;
        if (idx < 24 && in_pkt(pkt, idx)) exp_dup_a = 1;
        if (in_pkt(pkt, idx)) exp_dup_b = 1;
      end
      if (acc) begin
        pkt.push_back(idx);
        if (last) begin
          qa.push_back(build(pkt, 24, 0));
          qb.push_back(build(pkt, 32, 1));
          pkt.delete();
        end
      end
      if (acc && last) out_full = 1;
      else if (out_full && rdy) out_full = 0;
    end
    #1;
  endtask

  // Output monitor: valid must match pending expectations, data is compared on each handshake
  // and must stay frozen while downstream stalls.
  bit          hold_a = 0, hold_b = 0;
  logic [23:0] hold_a_dat;
  logic [31:0] hold_b_dat;
  exp_t        e;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_mask_valid", a_mvld, qa.size() != 0);
      chk("b_mask_valid", b_mvld, qb.size() != 0);
      if (a_mvld && hold_a) chk("a_mask_hold", a_mdat, hold_a_dat);
      if (b_mvld && hold_b) chk("b_mask_hold", b_mdat, hold_b_dat);
      if (a_mvld && mask_ready && qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_mask_data", a_mdat, e.m);
        chk("a_mask_cnt", a_cnt, e.c);
      end
      if (b_mvld && mask_ready && qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_mask_data", b_mdat, e.m);
        chk("b_mask_cnt", b_cnt, e.c);
      end
      hold_a     = a_mvld && !mask_ready;
      hold_b     = b_mvld && !mask_ready;
      hold_a_dat = a_mdat;
      hold_b_dat = b_mdat;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit v, last, rdy, clr, rst;
    int idx;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_valid", a_mvld, 0);
    chk("rst_a_data", a_mdat, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_err", a_erng, 0);
    chk("rst_a_ready", a_rdy, 1);
    chk("rst_b_valid", b_mvld, 0);
    chk("rst_b_data", b_mdat, 0);
    chk("rst_b_cnt", b_cnt, 0);
    mon_en = 1;
    @(posedge clk);
    #1;

    // 3, 0, 31 (last)
    cyc(1, 3, 0, 1, 0, 0); cyc(1, 0, 0, 1, 0, 0); cyc(1, 31, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 1, 0);
    // single beat index 0
    cyc(1, 0, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    // out-of-range 30, then 5 (last), then clear pulse
    cyc(1, 30, 0, 1, 0, 0); cyc(1, 5, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0); cyc(0, 0, 0, 1, 0, 0);
    // duplicate 7, 7 (last)
    cyc(1, 7, 0, 1, 0, 0); cyc(1, 7, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    // backpressure then back-to-back release with pending index 2
    cyc(1, 10, 1, 0, 0, 0);
    repeat (3) cyc(1, 2, 1, 0, 0, 0);
    cyc(1, 2, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0, 0);
    // reset mid-packet
    cyc(1, 1, 0, 1, 0, 0); cyc(1, 4, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 9, 1, 1, 0, 0); cyc(0, 0, 0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(0, 99) < 80);
      idx  = $urandom_range(0, 31);
      last = ($urandom_range(0, 99) < 25);
      rdy  = ($urandom_range(0, 99) < 70);
      clr  = ($urandom_range(0, 99) < 5);
      rst  = ($urandom_range(0, 199) == 0);
      if (rst) rdy = 0;
      cyc(v, idx, last, rdy, clr, rst);
    end
    // a long packet that touches every index exercises the full count
    for (int i = 0; i < 32; i++) cyc(1, i, (i == 31), 1, 0, 0);

    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
